// File: rtl/cpu_pkg.sv
// Shared types for the RV32I multi-cycle control path.
// ALU opcodes, sequencer states and base opcode constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SLL = 3'd5,
    SRL = 3'd6,
    SLT = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } seq_state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

endpackage

// File: rtl/seq_decoder.sv
// Combinational instruction decode: ALU opcode, operand
// select and illegal-encoding flag from the instruction register.
module seq_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_t     alu_op,
  output logic        alu_src_imm,
  output logic        illegal
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_is_r;
  logic       w_is_i;
  logic       w_sub;
  logic       w_unused;

  assign w_opc    = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign w_unused = ^{instr[24:15], instr[11:7]};

  assign w_is_r = (w_opc == OPC_OP) &&
                  ((w_f7 == 7'b0000000) ||
                   (w_f7 == 7'b0100000));
  assign w_is_i = (w_opc == OPC_OP_IMM);
  assign w_sub  = (w_opc == OPC_OP) &&
                  (w_f7 == 7'b0100000);

  assign illegal     = !(w_is_r || w_is_i);
  assign alu_src_imm = w_is_i;

  always_comb begin
    alu_op = ADD;
    unique case (1'b1)
      (w_f3 == 3'b000): alu_op = w_sub ? SUB : ADD;
      (w_f3 == 3'b001): alu_op = SLL;
      (w_f3 == 3'b010): alu_op = SLT;
      (w_f3 == 3'b011): alu_op = SLT;
      (w_f3 == 3'b100): alu_op = XOR;
      (w_f3 == 3'b101): alu_op = SRL;
      (w_f3 == 3'b110): alu_op = OR;
      (w_f3 == 3'b111): alu_op = AND;
      default:          alu_op = ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for RV32I ALU ops.
// Define SEQ_INSTRET_EN to build the retired-instruction counter.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_write,
  output logic        pc_write,
  output logic [2:0]  state,
  output logic        trap,
  output logic [31:0] instret
);

  seq_state_t r_state;
  seq_state_t w_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  alu_op_t     w_alu_op;
  logic        w_src_imm;
  logic        w_illegal;

  seq_decoder u_dec (
    .instr       (r_instr),
    .alu_op      (w_alu_op),
    .alu_src_imm (w_src_imm),
    .illegal     (w_illegal)
  );

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == IDLE):
        w_next = run ? FETCH : IDLE;
      (r_state == FETCH):
        w_next = imem_ready ? DECODE : FETCH;
      (r_state == DECODE):
        w_next = w_illegal ? TRAP : EXECUTE;
      (r_state == EXECUTE):
        w_next = WRITEBACK;
      (r_state == WRITEBACK):
        w_next = run ? FETCH : IDLE;
      default:
        w_next = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && imem_ready)
        r_instr <= imem_rdata;
      if (r_state == WRITEBACK)
        r_pc <= r_pc + 32'd4;
    end
  end

`ifdef SEQ_INSTRET_EN
  logic [31:0] r_instret;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_instret <= '0;
    else if (r_state == WRITEBACK)
      r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`else
  assign instret = '0;
`endif

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign alu_op      = w_alu_op;
  assign alu_src_imm = w_src_imm;
  // rd == x0 retires normally but never writes the register file
  assign pc_write    = (r_state == WRITEBACK);
  assign reg_write   = pc_write && (r_instr[11:7] != 5'd0);
  assign state       = r_state;
  assign trap        = (r_state == TRAP);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer with a cycle-level
// reference model and a wrap-around second instance.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic        reg_write;
  logic        pc_write;
  logic [2:0]  state;
  logic        trap;
  logic [31:0] instret;

  logic        run2;
  logic        req2;
  logic [31:0] addr2;
  logic        ready2;
  logic [31:0] rdata2;
  logic [31:0] pc2;
  logic [31:0] instr2;
  logic [2:0]  op2;
  logic        src2;
  logic        rw2;
  logic        pw2;
  logic [2:0]  st2;
  logic        trap2;
  logic [31:0] ret2;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int req_cnt;
  bit chk_en = 1'b0;
  logic [31:0] prog [16];

  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .reg_write(reg_write),
    .pc_write(pc_write), .state(state), .trap(trap),
    .instret(instret)
  );

  multicycle_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .run(run2),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ready(ready2), .imem_rdata(rdata2),
    .pc(pc2), .instr(instr2), .alu_op(op2),
    .alu_src_imm(src2), .reg_write(rw2),
    .pc_write(pw2), .state(st2), .trap(trap2),
    .instret(ret2)
  );

  assign ready2 = 1'b1;
  assign rdata2 = 32'h0016_0693;

  // memory answers on the lat-th consecutive request cycle
  assign imem_ready = imem_req && (req_cnt == lat - 1);
  assign imem_rdata = imem_ready ? prog[imem_addr[5:2]]
                                 : 32'hDEAD_BEEF;

  always @(posedge clk or negedge reset) begin
    if (!reset) req_cnt <= 0;
    else if (imem_req && !imem_ready) req_cnt <= req_cnt + 1;
    else req_cnt <= 0;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] w);
    logic [6:0] f7;
    f7 = w[31:25];
    if (w[6:0] == 7'h13) return 1'b1;
    if (w[6:0] == 7'h33 && (f7 == 7'h00 || f7 == 7'h20))
      return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] exp_op(input logic [31:0] w);
    logic [2:0] tbl [8];
    tbl = '{3'd0, 3'd5, 3'd7, 3'd7, 3'd4, 3'd6, 3'd3, 3'd2};
    if (w[14:12] == 3'b000 && w[6:0] == 7'h33 && w[31:25] == 7'h20)
      return 3'd1;
    return tbl[w[14:12]];
  endfunction

  // m_after counts cycles since the fetch completed (1..3)
  bit          m_fetch;
  bit          m_trapd;
  int          m_after;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ret;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fetch <= 1'b0;
      m_trapd <= 1'b0;
      m_after <= 0;
      m_pc    <= 32'h0;
      m_instr <= 32'h0;
      m_ret   <= 32'h0;
    end else if (m_trapd) begin
      m_trapd <= 1'b1;
    end else if (m_after == 0) begin
      if (m_fetch) begin
        if (imem_ready) begin
          m_instr <= imem_rdata;
          m_fetch <= 1'b0;
          m_after <= 1;
        end
      end else if (run) begin
        m_fetch <= 1'b1;
      end
    end else if (m_after == 1) begin
      if (legal(m_instr)) m_after <= 2;
      else begin
        m_trapd <= 1'b1;
        m_after <= 0;
      end
    end else if (m_after == 2) begin
      m_after <= 3;
    end else begin
      m_pc    <= m_pc + 32'd4;
      m_ret   <= m_ret + 32'd1;
      m_after <= 0;
      m_fetch <= run;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0]  est;
      logic [31:0] eret;
      bit          wb;
      wb  = (m_after == 3);
      est = m_trapd ? 3'd5 : m_fetch ? 3'd1 :
            (m_after == 0) ? 3'd0 : 3'(m_after + 1);
`ifdef SEQ_INSTRET_EN
      eret = m_ret;
`else
      eret = 32'h0;
`endif
      chk("state", {29'h0, state}, {29'h0, est});
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("imem_req", {31'h0, imem_req}, {31'h0, m_fetch});
      chk("instr", instr, m_instr);
      chk("trap", {31'h0, trap}, {31'h0, m_trapd});
      chk("pc_write", {31'h0, pc_write}, {31'h0, wb});
      chk("reg_write", {31'h0, reg_write},
          {31'h0, wb && (m_instr[11:7] != 5'd0)});
      chk("instret", instret, eret);
      if (m_after != 0) begin
        chk("alu_op", {29'h0, alu_op}, {29'h0, exp_op(m_instr)});
        chk("alu_src_imm", {31'h0, alu_src_imm},
            {31'h0, m_instr[6:0] == 7'h13});
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 32'h0;
    prog[0] = 32'h0053_03B3;
    prog[1] = 32'h4084_8533;
    prog[2] = 32'h0016_0693;
    prog[3] = 32'h0070_0293;
    prog[4] = 32'h0020_8033;
    prog[5] = 32'h0000_0000;
    reset = 1'b0;
    run   = 1'b0;
    run2  = 1'b0;
    lat   = 1;
    repeat (2) @(negedge clk);
    chk("rst_alu_op", {29'h0, alu_op}, 32'd0);
    chk("rst_src", {31'h0, alu_src_imm}, 32'd0);
    reset  = 1'b1;
    chk_en = 1'b1;

    repeat (10) @(negedge clk);
    chk("idle_state", {29'h0, state}, 32'd0);
    chk("idle_pc", pc, 32'd0);
    chk("idle_req", {31'h0, imem_req}, 32'd0);
    chk("idle_strb", {30'h0, reg_write, pc_write}, 32'd0);

    run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("zw_rw", {31'h0, reg_write}, {31'h0, (k % 4) == 0});
      if (k == 2) begin
        chk("zw_op0", {29'h0, alu_op}, 32'd0);
        chk("zw_src0", {31'h0, alu_src_imm}, 32'd0);
      end
      if (k == 6) begin
        chk("zw_op1", {29'h0, alu_op}, 32'd1);
        chk("zw_src1", {31'h0, alu_src_imm}, 32'd0);
      end
      if (k == 10) begin
        chk("zw_op2", {29'h0, alu_op}, 32'd0);
        chk("zw_src2", {31'h0, alu_src_imm}, 32'd1);
      end
      if (k == 12) run = 1'b0;
    end
    @(negedge clk);
    chk("zw_pc", pc, 32'd12);
    chk("zw_idle", {29'h0, state}, 32'd0);

    lat = 3;
    run = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        chk("ws_addr", imem_addr, 32'd12);
        chk("ws_req", {31'h0, imem_req}, 32'd1);
      end
      chk("ws_pw", {31'h0, pc_write}, {31'h0, k == 6});
      if (k == 2) run = 1'b0;
    end
    chk("ws_pc", pc, 32'd16);
    chk("ws_idle", {29'h0, state}, 32'd0);

    lat = 1;
    run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3) run = 1'b0;
      if (k == 4) begin
        chk("rd0_rw", {31'h0, reg_write}, 32'd0);
        chk("rd0_pw", {31'h0, pc_write}, 32'd1);
      end
    end
    chk("rd0_pc", pc, 32'd20);
    chk("rd0_idle", {29'h0, state}, 32'd0);

    run = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) chk("il_dec", {29'h0, state}, 32'd2);
      if (k == 3) begin
        chk("il_trap_st", {29'h0, state}, 32'd5);
        chk("il_trap", {31'h0, trap}, 32'd1);
      end
    end
    chk("il_pc", pc, 32'd20);
    chk("il_sticky", {29'h0, state}, 32'd5);
    run = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_state", {29'h0, state}, 32'd0);
    chk("ar_trap", {31'h0, trap}, 32'd0);
    chk("ar_pc", pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    lat = 5;
    run = 1'b1;
    repeat (2) @(negedge clk);
    chk("mf_req", {31'h0, imem_req}, 32'd1);
    #2 reset = 1'b0;
    #1 chk("mf_drop", {31'h0, imem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    chk("mf_idle", {29'h0, state}, 32'd0);
    chk("mf_pc", pc, 32'd0);

    chk("wr_pc0", pc2, 32'hFFFF_FFFC);
    run2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) run2 = 1'b0;
      if (k == 4) begin
        chk("wr_pw", {31'h0, pw2}, 32'd1);
        chk("wr_rw", {31'h0, rw2}, 32'd1);
      end
    end
    chk("wr_pc", pc2, 32'h0);
    chk("wr_idle", {29'h0, st2}, 32'd0);
`ifdef SEQ_INSTRET_EN
    chk("wr_instret", ret2, 32'd1);
`else
    chk("wr_instret", ret2, 32'd0);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control FSM that sequences the RV32I integer datapath (PC, instruction memory, register file, ALU) through fetch, decode, execute and writeback. It owns the program counter and instruction register and fetches over a req/ready handshake, so instruction memory may take several cycles. It decodes R-type and I-type ALU instructions into ALU opcodes and pulses the register-file and PC write enables once per retired instruction. Unsupported encodings send it to a sticky trap state.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; permits starting new instructions.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equals `pc`.
- `imem_ready`  in  1  fetch data valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `pc`  out  32  architectural PC.
- `instr`  out  32  instruction register.
- `alu_op`  out  3  `alu_op_t` for the ALU.
- `alu_src_imm`  out  1  1 = ALU B input is the sign-extended `instr[31:20]`.
- `reg_write`  out  1  register-file write enable (one-cycle pulse).
- `pc_write`  out  1  PC update strobe (one-cycle pulse).
- `state`  out  3  current `seq_state_t`.
- `trap`  out  1  illegal instruction seen (sticky).
- `instret`  out  32  retired-instruction count (see Configuration).

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
- IDLE:
  - Go to FETCH when `run`=1; otherwise stay.
- FETCH:
  - `imem_req`=1 with `imem_addr`=`pc`, held stable until `imem_ready`=1 is sampled.
  - On that edge, `instr` <= `imem_rdata` and the FSM goes to DECODE.
- DECODE:
  - Opcode 0110011 (R-type) with funct7 0000000 or 0100000 is legal.
  - Opcode 0010011 (I-type ALU) is legal.
  - Anything else, including R-type with any other funct7: go to TRAP, setting `trap`=1. No writes occur.
- `alu_op` mapping by funct3:
  - 000: SUB for R-type with funct7 0100000; ADD otherwise, including every I-type.
  - 001: SLL. 010: SLT. 011: SLT. 100: XOR. 101: SRL. 110: OR. 111: AND.
- Operand select: `alu_src_imm`=1 for I-type, 0 for R-type.
- `alu_op` and `alu_src_imm` are valid from DECODE through WRITEBACK and are held from `instr`.
- EXECUTE: one cycle for the datapath to settle.
- WRITEBACK:
  - `reg_write`=1, unless `instr[11:7]`==0, in which case the write is suppressed.
  - `pc_write`=1, and `pc` <= `pc`+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0).
  - Next state is FETCH if `run`=1, else IDLE.
- Deasserting `run` mid-instruction never aborts it; the instruction completes through WRITEBACK.
- TRAP: absorbing; `pc` is frozen at the faulting address. Only reset leaves TRAP.

## Timing
- Reset (async assert, sync release) forces:
  - state=IDLE, `pc`=`RESET_PC`, `instr`=0, `trap`=0, `instret`=0.
  - `imem_req`=0, `reg_write`=0, `pc_write`=0, `alu_op`=ADD, `alu_src_imm`=0.
- Latency: an instruction takes 3 + N cycles, where N ≥ 1 is the number of FETCH cycles.
  - Zero-wait memory gives 4 cycles per instruction.
  - The first `imem_req` is asserted 1 cycle after `run` is sampled in IDLE.
- `imem_ready` is ignored outside FETCH.
- `imem_req` is never deasserted before `imem_ready` is sampled.
- Reset asserted mid-fetch drops `imem_req` immediately; any pending response is ignored.
- `reg_write` and `pc_write` are always high together and only in WRITEBACK.
- Outputs are registered or decoded from state/`instr` only; no combinational path from `imem_rdata` to any output except through `instr`.

## Configuration
- `SEQ_INSTRET_EN` defined:
  - `instret` is a 32-bit counter incremented on every WRITEBACK cycle, including rd==0 instructions.
  - It wraps from 32'hFFFF_FFFF to 0 and is cleared by reset.
- `SEQ_INSTRET_EN` undefined: `instret` is tied to 0 and no counter flops exist.

## Structure
- Shared package `cpu_pkg`:
  - `alu_op_t` enum, logic [2:0]: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7.
  - `seq_state_t` enum, logic [2:0]: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, TRAP=5.
  - Opcode constants `OPC_OP`=7'b0110011 and `OPC_OP_IMM`=7'b0010011.
- Sub-module `seq_decoder`: combinational. It maps `instr` to `alu_op`, `alu_src_imm` and `illegal`, and is instantiated once.

## Test plan
- **Reset and idle:** release reset with `run`=0 for 10 cycles -> state=IDLE, `pc`=0, `imem_req`=0, all strobes 0.
- **Zero-wait sequence:** `imem_ready` tied to 1; program 0x005303B3 (add), 0x40848533 (sub), 0x00160693 (addi) -> `alu_op` ADD/SUB/ADD, `alu_src_imm` 0/0/1, `reg_write` pulses at cycles 4, 8 and 12 after `run`, `pc`=12.
- **Wait states:** `imem_ready` high only on the 3rd FETCH cycle -> `imem_addr` stable for 3 cycles, instruction latency 6 cycles.
- **Illegal instruction:** fetch 0x00000000 -> TRAP one cycle after DECODE, `trap`=1, no `reg_write` or `pc_write`, `pc` unchanged. Async reset then returns the block to IDLE.
- **rd=0 and run drop:** `add x0,x1,x2` (0x00208033) with `run` dropped during EXECUTE -> `reg_write`=0, `pc_write`=1, `pc`+=4, then IDLE.
- **PC wrap and counter:** `RESET_PC`=32'hFFFF_FFFC, one legal instruction -> `pc`=0. `instret`=1 with `SEQ_INSTRET_EN` defined, 0 without.
